// File: rtl/eig_watchdog_monitor.sv
// Oscillation watchdog for the eigenvalue core.
// It applies a persistence filter to hits and misses, and drives warn and alarm.
// The alarm is latched. It releases only after a healthy streak plus an explicit clear.
// It also keeps the peak underdamped kappa, a saturating result count and a sticky fault flag.
module eig_watchdog_monitor #(
  parameter int PERSIST   = 4,
  parameter int CLEAR_CNT = 8,
  parameter int W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                res_valid,
  input  logic signed [W-1:0] kappa,
  input  logic signed [W-1:0] inv_kappa,
  input  logic [2:0]          regime,
  input  logic signed [W-1:0] kappa_thr,
  input  logic                clear_alarm,
  output logic                warn,
  output logic                alarm,
  output logic [1:0]          mon_state,
  output logic [7:0]          hit_cnt,
  output logic [7:0]          miss_cnt,
  output logic signed [W-1:0] kappa_max,
  output logic [15:0]         res_cnt,
  output logic                fault
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2
  } mon_state_t;

  localparam logic signed [W-1:0] KMIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [7:0]          PERSIST_C = 8'(PERSIST);
  localparam logic [7:0]          CLEAR_C   = 8'(CLEAR_CNT);

  mon_state_t          st, st_n;
  logic [7:0]          hit_n, miss_n;
  logic signed [W-1:0] kmax_n;
  logic [15:0]         res_n;
  logic                fault_n;

  logic acc, onehot, ud, hit, miss, clr_ok;

  // Classify the incoming result
  always_comb begin
    acc    = ena && res_valid;
    onehot = (regime == 3'b001) || (regime == 3'b010) || (regime == 3'b100);
    ud     = (regime == 3'b001);
    hit    = acc && ((ud && (kappa > kappa_thr)) || !onehot);
    miss   = acc && !hit;
  end

  // Next-state, counters and statistics; a same-cycle result is applied before the clear
  always_comb begin
    st_n    = st;
    hit_n   = hit_cnt;
    miss_n  = miss_cnt;
    kmax_n  = kappa_max;
    res_n   = res_cnt;
    fault_n = fault;
    clr_ok  = 1'b0;

    if (acc) begin
      if (res_cnt != 16'hFFFF) res_n = res_cnt + 16'd1;
      if (!onehot || ((kappa != '0) && (inv_kappa == '0))) fault_n = 1'b1;
      if (ud && (kappa > kappa_max)) kmax_n = kappa;
    end

    case (st)
      ST_OK: begin
        if (hit) begin
          hit_n  = 8'd1;
          miss_n = 8'd0;
          st_n   = (PERSIST_C == 8'd1) ? ST_ALARM : ST_PEND;
        end else if (miss) begin
          hit_n = 8'd0;
        end
      end
      ST_PEND: begin
        if (hit) begin
          hit_n = hit_cnt + 8'd1;
          if (hit_n == PERSIST_C) begin
            st_n   = ST_ALARM;
            miss_n = 8'd0;
          end
        end else if (miss) begin
          st_n  = ST_OK;
          hit_n = 8'd0;
        end
      end
      ST_ALARM: begin
        if (hit) begin
          miss_n = 8'd0;
          if (hit_cnt != 8'hFF) hit_n = hit_cnt + 8'd1;
        end else if (miss) begin
          if (miss_cnt != 8'hFF) miss_n = miss_cnt + 8'd1;
        end
      end
      default: st_n = ST_OK;
    endcase

    clr_ok = clear_alarm && ena && (st == ST_ALARM) && (miss_n >= CLEAR_C);
    if (clr_ok) begin
      st_n    = ST_OK;
      hit_n   = 8'd0;
      miss_n  = 8'd0;
      kmax_n  = KMIN;
      fault_n = 1'b0;
    end
  end

  // State and statistics registers; ena low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_OK;
      hit_cnt   <= 8'd0;
      miss_cnt  <= 8'd0;
      kappa_max <= KMIN;
      res_cnt   <= 16'd0;
      fault     <= 1'b0;
    end else if (ena) begin
      st        <= st_n;
      hit_cnt   <= hit_n;
      miss_cnt  <= miss_n;
      kappa_max <= kmax_n;
      res_cnt   <= res_n;
      fault     <= fault_n;
    end
  end

  // Status outputs decode directly from the state register
  always_comb begin
    warn      = (st == ST_PEND);
    alarm     = (st == ST_ALARM);
    mon_state = st;
  end

endmodule
